// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives the ALU one-hot controls plus every datapath enable and mux select.
module multi_cycle_ctrl #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        reg_we,
    output logic        regdst_rd,
    output logic        memtoreg,
    output logic        mem_we,
    output logic        alusrc_imm,
    output logic        zext,
    output logic        cin,
    output logic        aluop,
    output logic        lui,
    output logic        add,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    // state | meaning
    // FETCH | IR write, PC += 4, latch opcode/funct
    // DECODE| jump, illegal trap, or proceed to EXEC
    // EXEC  | ALU operation; beq resolves here
    // MEM   | data-memory access (lw/sw)
    // WB    | register-file write
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    logic [2:0]  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [5:0]  funct_q, funct_d;
    logic [31:0] retired_q, retired_d;

    logic is_r, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal;
    logic retire;
    logic pc_we_c, ir_we_c, reg_we_c, regdst_c, memtoreg_c, mem_we_c;
    logic alusrc_c, zext_c, cin_c, aluop_c, lui_c, add_c, illegal_c;
    logic [1:0] pc_src_c;

    assign is_r    = (op_q == OP_RTYPE);
    assign is_addu = is_r && (funct_q == FN_ADDU);
    assign is_subu = is_r && (funct_q == FN_SUBU);
    assign is_ori  = (op_q == OP_ORI);
    assign is_lui  = (op_q == OP_LUI);
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_beq  = (op_q == OP_BEQ);
    assign is_j    = (op_q == OP_J);
    assign legal   = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

    always_comb begin
        state_d    = S_FETCH;
        op_d       = op_q;
        funct_d    = funct_q;
        retire     = 1'b0;
        pc_we_c    = 1'b0;
        pc_src_c   = 2'b00;
        ir_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        mem_we_c   = 1'b0;
        alusrc_c   = 1'b0;
        zext_c     = 1'b0;
        cin_c      = 1'b0;
        aluop_c    = 1'b0;
        lui_c      = 1'b0;
        add_c      = 1'b1;
        illegal_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                op_d    = instr[31:26];
                funct_d = instr[5:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_we_c  = 1'b1;
                    pc_src_c = 2'b10;
                    retire   = 1'b1;
                end else if (!legal) begin
                    illegal_c = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_addu) begin
                    state_d = S_WB;
                end else if (is_subu) begin
                    add_c   = 1'b0;
                    cin_c   = 1'b1;
                    state_d = S_WB;
                end else if (is_ori) begin
                    add_c    = 1'b0;
                    aluop_c  = 1'b1;
                    alusrc_c = 1'b1;
                    zext_c   = 1'b1;
                    state_d  = S_WB;
                end else if (is_lui) begin
                    add_c    = 1'b0;
                    lui_c    = 1'b1;
                    alusrc_c = 1'b1;
                    state_d  = S_WB;
                end else if (is_lw || is_sw) begin
                    alusrc_c = 1'b1;
                    state_d  = S_MEM;
                end else if (is_beq) begin
                    // the only Mealy output: branch taken when operands compare equal
                    add_c    = 1'b0;
                    cin_c    = 1'b1;
                    pc_src_c = 2'b01;
                    pc_we_c  = zero;
                    retire   = 1'b1;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    mem_we_c = 1'b1;
                    retire   = 1'b1;
                end else if (is_lw) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_we_c   = 1'b1;
                regdst_c   = is_r;
                memtoreg_c = is_lw;
                retire     = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = retired_q + {31'd0, retire};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RESET_STATE;
            op_q      <= 6'd0;
            funct_q   <= 6'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            retired_q <= retired_d;
        end
    end

    // Reset sits in FETCH; gate outputs so nothing writes while reset is held.
    assign pc_we      = reset & pc_we_c;
    assign pc_src     = reset ? pc_src_c : 2'b00;
    assign ir_we      = reset & ir_we_c;
    assign reg_we     = reset & reg_we_c;
    assign regdst_rd  = reset & regdst_c;
    assign memtoreg   = reset & memtoreg_c;
    assign mem_we     = reset & mem_we_c;
    assign alusrc_imm = reset & alusrc_c;
    assign zext       = reset & zext_c;
    assign cin        = reset & cin_c;
    assign aluop      = reset & aluop_c;
    assign lui        = reset & lui_c;
    assign add        = ~reset | add_c;
    assign illegal    = reset & illegal_c;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: a spec-level model pushes expected
// per-cycle outputs; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        pc_we, ir_we, reg_we, regdst_rd, memtoreg, mem_we;
    logic        alusrc_imm, zext, cin, aluop, lui, add, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [31:0] retired;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we),
        .regdst_rd(regdst_rd), .memtoreg(memtoreg), .mem_we(mem_we),
        .alusrc_imm(alusrc_imm), .zext(zext), .cin(cin), .aluop(aluop),
        .lui(lui), .add(add), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        ir_we, reg_we, regdst_rd, memtoreg, mem_we;
        logic        alusrc_imm, zext, cin, aluop, lui, add;
        logic [2:0]  state;
        logic        illegal;
        logic [31:0] retired;
    } obs_t;

    typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

    obs_t        sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] model_ret = 32'd0;

    function automatic obs_t sample();
        obs_t o;
        o = '{pc_we, pc_src, ir_we, reg_we, regdst_rd, memtoreg, mem_we,
              alusrc_imm, zext, cin, aluop, lui, add, state, illegal, retired};
        return o;
    endfunction

    function automatic kind_t classify(logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'd0:  return (fn == 6'd33) ? K_ADDU : (fn == 6'd35) ? K_SUBU : K_ILL;
            6'd13: return K_ORI;
            6'd15: return K_LUI;
            6'd35: return K_LW;
            6'd43: return K_SW;
            6'd4:  return K_BEQ;
            6'd2:  return K_J;
            default: return K_ILL;
        endcase
    endfunction

    // Expected outputs in one state of an instruction, straight from the op table.
    function automatic obs_t expect_state(int st, kind_t k, logic z, logic [31:0] ret);
        obs_t e;
        e = '0;
        e.add = 1'b1;
        e.state = 3'(st);
        e.retired = ret;
        case (st)
            0: begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
            1: begin
                if (k == K_J) begin e.pc_we = 1'b1; e.pc_src = 2'b10; end
                if (k == K_ILL) e.illegal = 1'b1;
            end
            2: begin
                e.add = (k == K_ADDU || k == K_LW || k == K_SW);
                e.cin = (k == K_SUBU || k == K_BEQ);
                e.aluop = (k == K_ORI);
                e.lui = (k == K_LUI);
                e.alusrc_imm = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
                e.zext = (k == K_ORI);
                if (k == K_BEQ) begin e.pc_src = 2'b01; e.pc_we = z; end
            end
            3: e.mem_we = (k == K_SW);
            4: begin
                e.reg_we = 1'b1;
                e.regdst_rd = (k == K_ADDU || k == K_SUBU);
                e.memtoreg = (k == K_LW);
            end
            default: ;
        endcase
        return e;
    endfunction

    // Pushes the expected per-cycle trace, drives the instruction, returns its cycle count.
    task automatic issue_start(input logic [31:0] ins, input logic z, output int ncyc);
        kind_t k;
        int path[$];
        k = classify(ins);
        case (k)
            K_J, K_ILL: path = '{0, 1};
            K_BEQ:      path = '{0, 1, 2};
            K_SW:       path = '{0, 1, 2, 3};
            K_LW:       path = '{0, 1, 2, 3, 4};
            default:    path = '{0, 1, 2, 4};
        endcase
        foreach (path[i]) sb_q.push_back(expect_state(path[i], k, z, model_ret));
        if (k != K_ILL) model_ret = model_ret + 32'd1;
        instr = ins;
        zero = z;
        ncyc = path.size();
    endtask

    task automatic issue(input logic [31:0] ins, input logic z);
        int n;
        issue_start(ins, z, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(logic [5:0] op, logic [5:0] fn);
        logic [31:0] r;
        r = $urandom;
        r[31:26] = op;
        r[5:0] = fn;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        int sel;
        sel = $urandom_range(0, 9);
        fn = 6'($urandom);
        case (sel)
            0: return mk(6'd0, 6'd33);
            1: return mk(6'd0, 6'd35);
            2: return mk(6'd13, fn);
            3: return mk(6'd15, fn);
            4: return mk(6'd35, fn);
            5: return mk(6'd43, fn);
            6: return mk(6'd4, fn);
            7: return mk(6'd2, fn);
            8: begin
                while (fn == 6'd33 || fn == 6'd35) fn = 6'($urandom);
                return mk(6'd0, fn);
            end
            default: begin
                op = 6'($urandom);
                while (op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd13 ||
                       op == 6'd15 || op == 6'd35 || op == 6'd43) op = 6'($urandom);
                return mk(op, fn);
            end
        endcase
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    function automatic obs_t reset_obs();
        obs_t e;
        e = '0;
        e.add = 1'b1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && sb_q.size() > 0) check("trace", sample(), sb_q.pop_front());
    end

    initial begin
        int n;
        reset = 1'b0;
        instr = 32'd0;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_init", sample(), reset_obs());
        @(posedge clk);
        #1;
        reset = 1'b1;

        // directed: ALU ops, memory, branches, jump, illegal
        issue(mk(6'd0, 6'd33), 1'b0);
        issue(mk(6'd0, 6'd35), 1'b1);
        issue(mk(6'd13, 6'd7), 1'b0);
        issue(mk(6'd15, 6'd1), 1'b0);
        check("retired_after_4", sample(), expect_state(0, K_ADDU, 1'b0, 32'd4));
        issue(mk(6'd35, 6'd0), 1'b0);
        issue(mk(6'd43, 6'd0), 1'b0);
        issue(mk(6'd4, 6'd0), 1'b1);
        issue(mk(6'd4, 6'd0), 1'b0);
        issue(32'h0800_0004, 1'b0);
        issue(32'hFC00_0000, 1'b0);
        check("retired_after_10", sample(), expect_state(0, K_ADDU, 1'b0, 32'd9));

        for (int i = 0; i < 200; i++) issue(rand_instr(), 1'($urandom));

        // reset in the MEM cycle of lw, held for three cycles
        issue_start(mk(6'd35, 6'd0), 1'b0, n);
        repeat (3) @(posedge clk);
        #1;
        check("lw_in_mem", sample(), expect_state(3, K_LW, 1'b0, model_ret - 32'd1));
        reset = 1'b0;
        sb_q.delete();
        model_ret = 32'd0;
        #1;
        check("reset_async", sample(), reset_obs());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_held", sample(), reset_obs());
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(mk(6'd0, 6'd33), 1'b0);
        issue(mk(6'd43, 6'd0), 1'b1);

        // retired wrap from FFFF_FFFF
        force dut.retired_q = 32'hFFFF_FFFF;
        model_ret = 32'hFFFF_FFFF;
        issue_start(mk(6'd0, 6'd33), 1'b0, n);
        @(posedge clk);
        #1;
        release dut.retired_q;
        repeat (n - 1) @(posedge clk);
        #1;
        check("retired_wrap", sample(), expect_state(0, K_ADDU, 1'b0, 32'd0));

        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle main controller for the MIPS datapath. It latches the instruction's opcode/funct fields, sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives the ALU's one-hot control inputs (`cin`, `aluop`, `lui`, `add`) and every datapath write enable and mux select. It consumes the ALU's `result` equality flag to resolve `beq`, and keeps a retired-instruction counter for bench checks.

## Interface
Parameters:
- `RESET_STATE`, 3'd0: state code loaded on reset (FETCH).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction-memory read data; sampled only in FETCH.
- `zero`  in  1  ALU equality flag (`w1 == w2`).
- `pc_we`  out  1  PC write enable.
- `pc_src`  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- `ir_we`  out  1  instruction-register write enable.
- `reg_we`  out  1  GRF write enable.
- `regdst_rd`  out  1  write-register select: 1 = rd, 0 = rt.
- `memtoreg`  out  1  write-back data: 1 = DM read data, 0 = ALU out.
- `mem_we`  out  1  DM write enable.
- `alusrc_imm`  out  1  ALU B operand: 1 = extended immediate, 0 = rt.
- `zext`  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- `cin`, `aluop`, `lui`, `add`  out  1 each  ALU controls: subtract, OR, load-upper, add.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- `illegal`  out  1  one-cycle pulse on an unsupported instruction.
- `retired`  out  32  count of completed legal instructions.

## Operation
- Supported instructions: `addu` (op 000000, funct 100001), `subu` (000000/100011), `ori` 001101, `lui` 001111, `lw` 100011, `sw` 101011, `beq` 000100, `j` 000010. Any other op/funct pair is illegal.
- The opcode and funct registers load from `instr` on the FETCH edge. Decoding uses only the latched copies.
- ALU controls are strictly one-hot in every cycle, with `add` as the default. The ALU holds its output when no control is set, so the all-zero pattern is forbidden.
- FETCH:
  - Outputs: `ir_we`=1, `pc_we`=1, `pc_src`=00.
  - Next state: DECODE.
- DECODE:
  - `j`: `pc_we`=1, `pc_src`=10, next state FETCH, retire.
  - Illegal instruction: `illegal`=1, next state FETCH, no retire.
  - Otherwise: next state EXEC.
- EXEC:
  - `addu`: `add`=1, next state WB.
  - `subu`: `cin`=1, next state WB.
  - `ori`: `aluop`=1, `alusrc_imm`=1, `zext`=1, next state WB.
  - `lui`: `lui`=1, `alusrc_imm`=1, next state WB.
  - `lw`/`sw`: `add`=1, `alusrc_imm`=1, `zext`=0, next state MEM.
  - `beq`:
    - Outputs: `cin`=1, `pc_src`=01, `pc_we`=`zero`. This Mealy path is the only one in the block.
    - Next state: FETCH, retire.
- MEM:
  - `sw`: `mem_we`=1, next state FETCH, retire.
  - `lw`: no enables, next state WB.
- WB:
  - Outputs: `reg_we`=1; `regdst_rd`=1 for R-type only; `memtoreg`=1 for `lw` only.
  - Next state: FETCH, retire.
- Cycles per instruction: `j` 2, illegal 2, `beq` 3, `addu`/`subu`/`ori`/`lui`/`sw` 4, `lw` 5.
- `retired` increments by 1 on the final-state edge of each legal instruction and wraps from FFFF_FFFF to 0.
- Any unused `state` encoding (5–7) returns to FETCH on the next edge. No outputs are asserted in that cycle except `add`.

## Timing
- Reset (`reset`=0, asynchronous):
  - `state`=FETCH, opcode/funct registers=0, `retired`=0.
  - All write enables, `illegal`, `cin`, `aluop`, `lui` = 0; `add`=1; `pc_src`=00.
- While `reset` is low, FETCH outputs are suppressed. The first FETCH write happens on the first rising edge after `reset` goes high.
- Reset asserted mid-instruction aborts it immediately. No enable may be seen high after `reset` falls, and `retired` is not incremented.
- All outputs except `pc_we` in the `beq` EXEC cycle are pure functions of `state` and the latched fields. They settle within the cycle, and writes take effect on the next rising edge.
- `instr` must be valid at the FETCH rising edge; it is ignored in all other states.
- `zero` must be valid before the rising edge that ends the EXEC cycle of `beq`.

## Test plan
- Reset mid-`lw` in MEM, held for 3 cycles, then released:
  - While held: `state`=0, `retired`=0, all enables 0, `add`=1.
  - After release: the next edge performs FETCH.
- Sequence `addu`, `subu`, `ori`, `lui`, all in WB:
  - `state` trace 0,1,2,4 per instruction.
  - EXEC controls are exactly `add`, `cin`, `aluop`+`zext`, `lui` respectively.
  - `regdst_rd` is 1, 1, 0, 0.
  - `retired`=4 after 16 cycles.
- `lw` then `sw`:
  - `lw`: 5 cycles, `memtoreg`=1 with `reg_we`=1 in WB.
  - `sw`: `mem_we`=1 only in its MEM cycle.
  - `retired`=2.
- `beq` with `zero`=1, then `beq` with `zero`=0:
  - First: `pc_we`=1, `pc_src`=01 in EXEC.
  - Second: `pc_we`=0.
  - Each takes 3 cycles.
- `j` (instr 0x08000004), then illegal opcode 0xFC000000:
  - `j`: `pc_we`=1, `pc_src`=10 in DECODE.
  - Illegal: `illegal` pulses for one cycle, `retired` does not increment, returns to FETCH.
- Preload `retired`=FFFF_FFFF via a 2^32-instruction shortcut (force), then run one `addu`: `retired` wraps to 0.
